rr_encoded_arbiter: RTL
=======================

Name: rr_encoded_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource between 8 requesters.
- Holds a registered one-hot grant and its binary index; the index is the same encoding the team's 8-to-3 binary encoder produces, so it can drive a mux select directly.
- Releases the grant on completion or on requester drop, and forcibly preempts a holder that exceeds a hold budget while others are waiting.
- Sits between requester agents and a shared datapath or bus.

Parameters:
- N_REQ, 8, number of requesters (fixed at 8 for this revision).
- IDX_W, 3, index width, equal to log2(N_REQ).
- HOLD_MAX, 16, maximum number of BUSY cycles before preemption when other requests are pending; 0 disables preemption.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i belongs to requester i.
- done  input  1  holder finished; sampled only in BUSY.
- gnt  output  8  one-hot grant, registered.
- gnt_idx  output  3  binary index of the set gnt bit, registered.
- gnt_valid  output  1  high while a grant is held.
- preempt  output  1  one-cycle pulse in the cycle after a forced release.

Behaviour:
- Reset (rst=1 at an edge) forces:
  - gnt=0, gnt_idx=0, gnt_valid=0, preempt=0;
  - state=IDLE, ptr=0, hold_cnt=0.
- Reset mid-grant drops the grant at that same edge. No release bookkeeping: ptr returns to 0.
- States: IDLE and BUSY.
- IDLE, req==0: stay in IDLE; outputs stay 0.
- IDLE, req!=0 sampled at edge n:
  - winner = first set bit scanning ptr, ptr+1, … modulo 8;
  - after edge n: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0, state=BUSY.
  - Arbitration latency is 1 cycle.
- BUSY: gnt, gnt_idx and gnt_valid are stable. hold_cnt increments each cycle and saturates at HOLD_MAX-1.
- BUSY release conditions, any of:
  - (a) done=1;
  - (b) req[gnt_idx]=0;
  - (c) HOLD_MAX!=0, hold_cnt==HOLD_MAX-1, and (req with the holder bit masked)!=0.
- On a release edge:
  - ptr <= (gnt_idx+1) mod 8, wrapping 7 to 0;
  - gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE.
- Handoff: exactly one dead cycle with gnt_valid=0. The next grant appears on the following edge if requests are pending.
- preempt=1 for the single cycle after a release caused only by (c). If (a) or (b) holds in the same cycle, the release is normal and preempt=0.
- A holder that still requests after its release is arbitrated last, because ptr has moved past it.
- Requests arriving or dropping in BUSY for non-holders have no effect until the next IDLE arbitration.
- hold_cnt==HOLD_MAX-1 with no other requester pending: no preemption; the holder keeps the grant indefinitely.
- gnt is always zero or one-hot. gnt_idx is 0 whenever gnt_valid=0.

Decomposition:
- Package arb_pkg holds:
  - constants N_REQ=8 and IDX_W=3;
  - state enum {IDLE, BUSY};
  - function onehot_to_idx (8-to-3 encode, lowest set bit wins for robustness).
- One combinational sub-module, rr_priority_pick:
  - inputs req[7:0] and ptr[2:0];
  - outputs winner_oh[7:0], winner_idx[2:0], any.
  - Implementation: rotate right by ptr, take the lowest set bit, rotate back.
- The top level holds the state register, ptr, hold_cnt and the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0, preempt=0 throughout.
- Single requester: after reset, req=8'b0000_0100 -> next edge gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1. A 1-cycle done pulse -> gnt_valid=0 the next cycle; with req still high, regrant to idx 2 one cycle later.
- Fairness sweep: req=8'hFF held, done pulsed in each grant cycle -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, each separated by exactly one gnt_valid=0 cycle.
- Wrap and pointer: grant idx 7 released via done, then req=8'b1000_0001 -> next grant idx 0, then idx 7 after release.
- Preemption with HOLD_MAX=4: req=8'b0000_0011, done=0 -> idx 0 held for 4 cycles, preempt=1 for one cycle with gnt_valid=0, then gnt_idx=1.
  - Same setup with req=8'b0000_0001 -> no preempt; idx 0 is held for 20+ cycles.
- Mid-grant reset and drop: while idx 5 is granted, assert rst for 1 cycle -> all outputs 0 at that edge; the next arbitration starts from ptr=0.
  - Separately, deasserting req[holder] -> release on the next edge with preempt=0.

Source files
------------

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin encoded arbiter:
//   N_REQ         - number of requesters (8)
//   IDX_W         - width of a requester index (3)
//   arb_state_t   - arbiter state encoding (IDLE / BUSY)
//   onehot_to_idx - 8-to-3 encoder; if several bits are set, the lowest wins
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Scanning from the top down lets the lowest set bit overwrite any higher
  // one, so a corrupted multi-hot input still yields a well-defined index.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (oh[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin pick: the first set request bit found when
// scanning ptr, ptr+1, ... (mod N_REQ).
// Ports:
//   req        in  [N_REQ-1:0] request vector
//   ptr        in  [IDX_W-1:0] highest-priority position
//   winner_oh  out [N_REQ-1:0] one-hot winner (0 when no request)
//   winner_idx out [IDX_W-1:0] binary index of the winner (0 when none)
//   any        out             at least one request is set
// -----------------------------------------------------------------------------
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any
);

  localparam logic [N_REQ-1:0] ONE_N = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_rot_low;

  // Rotate right by ptr so the highest-priority requester sits at bit 0.
  // The IDX_W-bit index sum wraps modulo N_REQ on its own.
  always_comb begin
    w_rot = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      w_rot[i] = req[IDX_W'(i) + ptr];
    end
  end

  // Isolate the lowest set bit of the rotated vector (x & -x).
  assign w_rot_low = w_rot & (~w_rot + ONE_N);

  // Rotate the isolated bit back left by ptr to its original position.
  always_comb begin
    winner_oh = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      winner_oh[IDX_W'(i) + ptr] = w_rot_low[i];
    end
  end

  assign winner_idx = onehot_to_idx(winner_oh);
  assign any        = |req;

endmodule

// File: rtl/rr_encoded_arbiter.sv
// -----------------------------------------------------------------------------
// rr_encoded_arbiter
// Round-robin arbiter sharing one resource among 8 requesters. It holds a
// registered one-hot grant plus its binary index, releases the grant on done
// or on holder drop, and preempts a holder that reaches its hold budget while
// other requesters are waiting. Every release is followed by one dead cycle.
// Parameters:
//   HOLD_MAX  BUSY cycles allowed before preemption (0 disables preemption)
// Ports:
//   clk        in         rising-edge clock
//   rst        in         synchronous active-high reset
//   req        in  [7:0]  request vector, bit i = requester i
//   done       in         holder finished (looked at only while BUSY)
//   gnt        out [7:0]  registered one-hot grant
//   gnt_idx    out [2:0]  registered binary index of gnt (0 when idle)
//   gnt_valid  out        a grant is held
//   preempt    out        one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module rr_encoded_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam int                CNT_W       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int                HOLD_LAST_I = (HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0;
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_LAST_I);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);
  localparam logic              PREEMPT_EN  = (HOLD_MAX != 0);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_gnt_idx_nxt;
  logic             r_gnt_valid;
  logic             w_gnt_valid_nxt;
  logic             r_preempt;
  logic             w_preempt_nxt;

  logic [N_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_any;
  logic             w_holder_req;
  logic             w_others;
  logic             w_budget_hit;
  logic             w_release;
  logic             w_forced;

  rr_priority_pick u_pick (
    .req        (req),
    .ptr        (r_ptr),
    .winner_oh  (w_win_oh),
    .winner_idx (w_win_idx),
    .any        (w_any)
  );

  // Holder status; r_gnt doubles as the mask that removes the holder bit.
  assign w_holder_req = req[r_gnt_idx];
  assign w_others     = |(req & ~r_gnt);
  assign w_budget_hit = PREEMPT_EN && (r_hold_cnt == HOLD_LAST) && w_others;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and release decode. A budget release only counts as
  // forced when neither done nor a holder drop would have released anyway.
  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    w_forced    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        w_release = done | ~w_holder_req | w_budget_hit;
        w_forced  = w_budget_hit & ~done & w_holder_req;
        if (w_release) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_hold_nxt      = r_hold_cnt;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_preempt_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_hold_nxt = {CNT_W{1'b0}};
        if (w_any) begin
          w_gnt_nxt       = w_win_oh;
          w_gnt_idx_nxt   = w_win_idx;
          w_gnt_valid_nxt = 1'b1;
        end else begin
          w_gnt_nxt       = {N_REQ{1'b0}};
          w_gnt_idx_nxt   = {IDX_W{1'b0}};
          w_gnt_valid_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (w_release) begin
          // Move priority just past the holder so it is served last next time.
          w_ptr_nxt       = r_gnt_idx + IDX_ONE;
          w_hold_nxt      = {CNT_W{1'b0}};
          w_gnt_nxt       = {N_REQ{1'b0}};
          w_gnt_idx_nxt   = {IDX_W{1'b0}};
          w_gnt_valid_nxt = 1'b0;
          w_preempt_nxt   = w_forced;
        end else if (r_hold_cnt != HOLD_LAST) begin
          w_hold_nxt = r_hold_cnt + CNT_ONE;
        end else begin
          w_hold_nxt = r_hold_cnt;
        end
      end
      default: begin
        w_ptr_nxt       = {IDX_W{1'b0}};
        w_hold_nxt      = {CNT_W{1'b0}};
        w_gnt_nxt       = {N_REQ{1'b0}};
        w_gnt_idx_nxt   = {IDX_W{1'b0}};
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output, pointer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= {IDX_W{1'b0}};
      r_hold_cnt  <= {CNT_W{1'b0}};
      r_gnt       <= {N_REQ{1'b0}};
      r_gnt_idx   <= {IDX_W{1'b0}};
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_preempt   <= w_preempt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign preempt   = r_preempt;

endmodule
